// File: rtl/logic_unit_pipe_if.sv
// Operand/result stream bundle for logic_unit_pipe.
// The slave modport is the unit; the master modport is the producer/consumer side.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             out_match;
  logic             out_zero;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, out, out_match, out_zero
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, out, out_match, out_zero
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready flow control.
// Optional saturating match counter enabled by defining LOGIC_UNIT_MATCH_CNT_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  logic_unit_pipe_if.slave   bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   match_cnt
);

  logic             r_s1V;
  logic [WIDTH-1:0] r_s1A;
  logic [WIDTH-1:0] r_s1B;
  logic [2:0]       r_s1Op;
  logic             r_outValid;
  logic [WIDTH-1:0] r_out;
  logic             r_match;
  logic             r_zero;

  logic             w_s2Load;
  logic             w_inReady;
  logic [WIDTH-1:0] w_result;

  assign w_s2Load  = r_s1V && (!r_outValid || bus.out_ready);
  // Held low during reset so no beat can be taken while state is being cleared.
  assign w_inReady = !rst && (!r_s1V || w_s2Load);

  always_comb begin
    w_result = '0;
    case (r_s1Op)
      3'b000:  w_result = r_s1A & r_s1B;
      3'b001:  w_result = r_s1A | r_s1B;
      3'b010:  w_result = r_s1A ^ r_s1B;
      3'b011:  w_result = r_s1A ~^ r_s1B;
      3'b100:  w_result = ~(r_s1A & r_s1B);
      3'b101:  w_result = ~(r_s1A | r_s1B);
      3'b110:  w_result = ~r_s1A;
      3'b111:  w_result = r_s1A;
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1V  <= 1'b0;
      r_s1A  <= '0;
      r_s1B  <= '0;
      r_s1Op <= '0;
    end else if (w_inReady) begin
      r_s1V <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1A  <= bus.a;
        r_s1B  <= bus.b;
        r_s1Op <= bus.op;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= 1'b0;
      r_out      <= '0;
      r_match    <= 1'b0;
      r_zero     <= 1'b0;
    end else if (w_s2Load) begin
      r_outValid <= 1'b1;
      r_out      <= w_result;
      r_match    <= &(r_s1A ~^ r_s1B);
      r_zero     <= ~|w_result;
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
    end
  end

`ifdef LOGIC_UNIT_MATCH_CNT_EN
  logic [CNT_W-1:0] r_matchCnt;

  // Clear dominates; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_matchCnt <= '0;
    end else if (r_outValid && bus.out_ready && r_match &&
                 (r_matchCnt != {CNT_W{1'b1}})) begin
      r_matchCnt <= r_matchCnt + CNT_W'(1);
    end
  end

  assign match_cnt = r_matchCnt;
`else
  logic w_unusedCntClr;
  assign w_unusedCntClr = cnt_clr;
  assign match_cnt      = '0;
`endif

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out       = r_out;
  assign bus.out_match = r_match;
  assign bus.out_zero  = r_zero;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe; a second CNT_W=2 instance shares the
// stimulus to exercise counter saturation.
module tb_logic_unit_pipe;

  logic        clk;
  logic        rst;
  logic        cntClr;
  logic [15:0] matchCnt0;
  logic [1:0]  matchCnt1;
  int          total;
  int          bad;

`ifdef LOGIC_UNIT_MATCH_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic_unit_pipe_if #(.WIDTH(8)) bus0 ();
  logic_unit_pipe_if #(.WIDTH(8)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.a         = bus0.a;
  assign bus1.b         = bus0.b;
  assign bus1.op        = bus0.op;
  assign bus1.out_ready = bus0.out_ready;

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .cnt_clr(cntClr), .match_cnt(matchCnt0)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .cnt_clr(cntClr), .match_cnt(matchCnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] op);
    bus0.in_valid = valid;
    bus0.a        = a;
    bus0.b        = b;
    bus0.op       = op;
  endtask

  function automatic logic [31:0] expCnt(input int n);
    return CntEn ? 32'(n) : 32'd0;
  endfunction

  logic [7:0] sweepExp [8];

  initial begin
    total = 0;
    bad   = 0;
    sweepExp = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};

    // Reset state
    rst = 1'b1;
    cntClr = 1'b0;
    bus0.out_ready = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    step();
    step();
    checkOutput("rst_in_ready", 32'(bus0.in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("rst_out", 32'(bus0.out), 32'd0);
    checkOutput("rst_match", 32'(bus0.out_match), 32'd0);
    checkOutput("rst_zero", 32'(bus0.out_zero), 32'd0);
    checkOutput("rst_cnt", 32'(matchCnt0), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);

    // Single XNOR beat with matching operands
    applyStimulus(1'b1, 8'hA5, 8'hA5, 3'b011);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    checkOutput("lat_not_yet", 32'(bus0.out_valid), 32'd0);
    step();
    checkOutput("xnor_valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("xnor_out", 32'(bus0.out), 32'hFF);
    checkOutput("xnor_match", 32'(bus0.out_match), 32'd1);
    checkOutput("xnor_zero", 32'(bus0.out_zero), 32'd0);
    step();
    checkOutput("xnor_drained", 32'(bus0.out_valid), 32'd0);
    checkOutput("xnor_cnt", 32'(matchCnt0), expCnt(1));

    // Sweep all ops back to back
    for (int i = 0; i < 9; i++) begin
      if (i < 8) applyStimulus(1'b1, 8'hF0, 8'hCC, 3'(i));
      else       applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
      step();
      if (i >= 1) begin
        checkOutput($sformatf("sweep_valid_%0d", i - 1), 32'(bus0.out_valid), 32'd1);
        checkOutput($sformatf("sweep_out_%0d", i - 1), 32'(bus0.out), 32'(sweepExp[i-1]));
        checkOutput($sformatf("sweep_match_%0d", i - 1), 32'(bus0.out_match), 32'd0);
        checkOutput($sformatf("sweep_zero_%0d", i - 1), 32'(bus0.out_zero), 32'd0);
      end
    end
    step();
    checkOutput("sweep_drained", 32'(bus0.out_valid), 32'd0);

    // Ten-beat stream, pass-a, full throughput
    for (int i = 0; i < 11; i++) begin
      if (i < 10) applyStimulus(1'b1, 8'(i + 1), 8'h00, 3'b111);
      else        applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
      #1;
      if (i < 10) checkOutput($sformatf("stream_in_ready_%0d", i), 32'(bus0.in_ready), 32'd1);
      step();
      if (i >= 1) begin
        checkOutput($sformatf("stream_valid_%0d", i - 1), 32'(bus0.out_valid), 32'd1);
        checkOutput($sformatf("stream_out_%0d", i - 1), 32'(bus0.out), 32'(i));
      end
    end
    step();
    checkOutput("stream_drained", 32'(bus0.out_valid), 32'd0);

    // Backpressure: fill both stages, hold, then drain
    bus0.out_ready = 1'b0;
    applyStimulus(1'b1, 8'h11, 8'h00, 3'b111);
    step();
    checkOutput("bp_ready_after1", 32'(bus0.in_ready), 32'd1);
    applyStimulus(1'b1, 8'h22, 8'h00, 3'b111);
    step();
    checkOutput("bp_full_ready", 32'(bus0.in_ready), 32'd0);
    checkOutput("bp_full_valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("bp_full_out", 32'(bus0.out), 32'h11);
    applyStimulus(1'b1, 8'h33, 8'h00, 3'b111);
    step();
    step();
    checkOutput("bp_hold_ready", 32'(bus0.in_ready), 32'd0);
    checkOutput("bp_hold_out", 32'(bus0.out), 32'h11);
    bus0.out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(bus0.in_ready), 32'd1);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    checkOutput("bp_drain0_valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("bp_drain0_out", 32'(bus0.out), 32'h22);
    step();
    checkOutput("bp_drain1_valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("bp_drain1_out", 32'(bus0.out), 32'h33);
    step();
    checkOutput("bp_drained", 32'(bus0.out_valid), 32'd0);
    checkOutput("bp_cnt", 32'(matchCnt0), expCnt(1));

    // Counter: clear, saturate the 2-bit instance
    cntClr = 1'b1;
    step();
    cntClr = 1'b0;
    checkOutput("clr_cnt0", 32'(matchCnt0), 32'd0);
    checkOutput("clr_cnt1", 32'(matchCnt1), 32'd0);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) applyStimulus(1'b1, 8'h07, 8'h07, 3'b000);
      else       applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
      step();
    end
    checkOutput("sat_drained", 32'(bus0.out_valid), 32'd0);
    checkOutput("sat_cnt16", 32'(matchCnt0), expCnt(5));
    checkOutput("sat_cnt2", 32'(matchCnt1), expCnt(3));

    // Clear beats a simultaneous matching transfer
    applyStimulus(1'b1, 8'h09, 8'h09, 3'b000);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    step();
    checkOutput("clrwin_pre_valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("clrwin_pre_match", 32'(bus0.out_match), 32'd1);
    checkOutput("clrwin_pre_cnt", 32'(matchCnt0), expCnt(5));
    cntClr = 1'b1;
    step();
    cntClr = 1'b0;
    checkOutput("clrwin_cnt16", 32'(matchCnt0), 32'd0);
    checkOutput("clrwin_cnt2", 32'(matchCnt1), 32'd0);

    // Reset with both stages full discards everything
    bus0.out_ready = 1'b0;
    applyStimulus(1'b1, 8'h3C, 8'h3C, 3'b011);
    step();
    step();
    checkOutput("rstfull_valid", 32'(bus0.out_valid), 32'd1);
    checkOutput("rstfull_ready", 32'(bus0.in_ready), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 8'h00, 3'd0);
    step();
    checkOutput("rstfull_out_valid", 32'(bus0.out_valid), 32'd0);
    checkOutput("rstfull_out", 32'(bus0.out), 32'd0);
    checkOutput("rstfull_cnt", 32'(matchCnt0), 32'd0);
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("no_stale_%0d", i), 32'(bus0.out_valid), 32'd0);
    end
    checkOutput("no_stale_cnt", 32'(matchCnt0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit. It is the successor to the single-bit two-input gate modules: it handles WIDTH-bit operands, a selectable operation (XNOR among eight), an equality flag and an optional saturating match counter. It sits between operand producers and result consumers, with valid/ready flow control on both sides.

## Interface
- WIDTH, 8: operand/result width in bits, ≥1
- CNT_W, 16: match counter width, ≥1
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation select, sampled with the beat
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts the result
- out  out  WIDTH  result
- out_match  out  1  a == b for this beat
- out_zero  out  1  result == 0
- cnt_clr  in  1  synchronous clear of match_cnt
- match_cnt  out  CNT_W  count of delivered beats with out_match=1

## Operation
- op encoding:
  - 000 AND, 001 OR, 010 XOR, 011 XNOR
  - 100 NAND, 101 NOR, 110 NOT a (b ignored), 111 pass a
- Two register stages:
  - S1 holds a, b and op with valid s1_v.
  - S2 holds out, out_match and out_zero with valid out_valid.
- Outputs are computed from S1 contents when S2 loads:
  - out_match = &(a ~^ b), independent of op.
  - out_zero = ~|result.
- S2 advance: s2_load = s1_v && (!out_valid || out_ready).
- S1 advance: in_ready = !s1_v || s2_load. A beat is accepted when in_valid && in_ready.
- Transfer out when out_valid && out_ready. out_valid clears if no new load occurs in that cycle.
- Simultaneous transfer-out and load: S2 takes the new beat and out_valid stays 1. Full throughput is 1 beat/cycle.
- Outputs are held stable while out_valid && !out_ready.
- in_valid may drop without acceptance. S1 never captures a beat unless in_ready=1.
- match_cnt (when configured) increments on each output transfer with out_match=1.
  - It saturates at 2^CNT_W−1 and does not wrap.
  - cnt_clr=1 forces 0; clear wins over a simultaneous increment.

## Timing
- Reset (rst=1 at an edge) produces:
  - s1_v=0, out_valid=0, out=0, out_match=0, out_zero=0, match_cnt=0.
  - in_ready=0 while rst is high, and 1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats. Nothing is delivered for them and the count is unchanged by them.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1 (2 edges), provided S2 was free.
- in_ready is combinational from s1_v, out_valid and out_ready. There is no combinational path from in_valid, a, b or op to any output.
- Backpressure: with out_ready=0 the unit fills (S1 and S2 both valid), then in_ready=0. Exactly 2 beats are buffered and none are lost or duplicated.

## Configuration
- LOGIC_UNIT_MATCH_CNT_EN defined: match_cnt register and cnt_clr are implemented as described.
- LOGIC_UNIT_MATCH_CNT_EN undefined: match_cnt is constant 0, cnt_clr is ignored, and no counter flops exist. All other behaviour is identical.

## Test plan
- Reset, then a=8'hA5, b=8'hA5, op=011, out_ready=1 → out=8'hFF, out_match=1, out_zero=0 two edges after acceptance; match_cnt=1 (macro on).
- Sweep all 8 ops with a=8'hF0, b=8'hCC → out = C0, FC, 3C, C3, 3F, 03, 0F, F0 in order; out_match=0 throughout.
- Stream 10 back-to-back beats, out_ready=1 → in_ready stays 1, 10 results arrive in order on consecutive cycles.
- Hold out_ready=0 with in_valid=1 → in_ready falls after 2 accepted beats and out stays stable. Then release → the buffered beats drain in order with no loss or duplicate.
- CNT_W=2: deliver 5 matching beats → match_cnt saturates at 3. Assert cnt_clr in the same cycle as a matching transfer → match_cnt=0.
- Assert rst with both stages full → out_valid=0, match_cnt=0 next cycle, and no stale beat appears afterwards.
